// File: rtl/video_timing_if.sv
// video_timing_if: control inputs and raster outputs of the video timing generator.
// The generator side uses the master modport; the TMDS consumer side uses slave.
interface video_timing_if;
  logic       enable;
  logic       restart;
  logic       pixelclk;
  logic [9:0] colcount;
  logic [9:0] rowcount;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       line_end;
  logic       frame_start;

  modport master (
    input  enable, restart,
    output pixelclk, colcount, rowcount, hsync, vsync, de, line_end, frame_start
  );

  modport slave (
    output enable, restart,
    input  pixelclk, colcount, rowcount, hsync, vsync, de, line_end, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with blanking placed first in each
// line and frame. A clock divider produces the pixel strobe; column/row counters
// advance on it, and sync/enable levels are registered from the next counts so
// they line up with the counts they describe.
module video_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           n_rst,
  video_timing_if.master vt
);

  localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
  localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
  localparam int DIV_W   = (CLK_DIV >= 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       COL_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]       ROW_LAST = 10'(V_TOTAL - 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("video_timing_gen: CLK_DIV must be at least 2");
  end
  if (H_TOTAL > 1023) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL exceeds 1023");
  end
  if (V_TOTAL > 1023) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL exceeds 1023");
  end

  // Sync is asserted in the window right after the front porch.
  function automatic logic hsync_level(input logic [9:0] col);
    if ((col >= 10'(H_FP)) && (col < 10'(H_FP + H_SYNC))) begin
      return SYNC_POL;
    end else begin
      return ~SYNC_POL;
    end
  endfunction

  function automatic logic vsync_level(input logic [9:0] row);
    if ((row >= 10'(V_FP)) && (row < 10'(V_FP + V_SYNC))) begin
      return SYNC_POL;
    end else begin
      return ~SYNC_POL;
    end
  endfunction

  // Active video sits at the end of each line and frame.
  function automatic logic de_level(input logic [9:0] col, input logic [9:0] row);
    return (col >= 10'(H_TOTAL - H_ACTIVE)) && (row >= 10'(V_TOTAL - V_ACTIVE));
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             line_end_q, line_end_d;
  logic             frame_start_q, frame_start_d;
  logic             pixel_s;

  // Pixel strobe: last clk of the pixel period, suppressed by restart or freeze.
  assign pixel_s = vt.enable & (div_q == DIV_LAST) & ~vt.restart;

  // Next-state: restart wins, otherwise divider/counters advance only while enabled.
  always_comb begin
    div_d         = div_q;
    col_d         = col_q;
    row_d         = row_q;
    line_end_d    = 1'b0;
    frame_start_d = 1'b0;
    if (vt.restart) begin
      div_d = '0;
      col_d = '0;
      row_d = '0;
    end else if (vt.enable) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (pixel_s) begin
        if (col_q == COL_LAST) begin
          col_d      = 10'd0;
          line_end_d = 1'b1;
          if (row_q == ROW_LAST) begin
            row_d         = 10'd0;
            frame_start_d = 1'b1;
          end else begin
            row_d = row_q + 10'd1;
          end
        end else begin
          col_d = col_q + 10'd1;
        end
      end else begin
        col_d = col_q;
      end
    end else begin
      div_d = div_q;
    end
    // Decodes follow the next counts; with counts held they hold too.
    hsync_d = hsync_level(col_d);
    vsync_d = vsync_level(row_d);
    de_d    = de_level(col_d, row_d);
  end

  // State and registered decode flops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q         <= '0;
      col_q         <= 10'd0;
      row_q         <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vt.pixelclk    = pixel_s;
  assign vt.colcount    = col_q;
  assign vt.rowcount    = row_q;
  assign vt.hsync       = hsync_q;
  assign vt.vsync       = vsync_q;
  assign vt.de          = de_q;
  // Pulses are forced low while the timing is frozen.
  assign vt.line_end    = line_end_q & vt.enable;
  assign vt.frame_start = frame_start_q & vt.enable;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: drives a full-size and a shrunk-geometry generator with
// the same enable/restart stimulus and compares every output against a model
// built from a linear count of enabled clocks since the last restart.
module tb_video_timing_gen;
  localparam int CD = 4;
  // full-size geometry
  localparam int BHFP = 16, BHS = 96, BHA = 640, BHT = 800;
  localparam int BVFP = 10, BVS = 2,  BVA = 480, BVT = 525;
  // shrunk geometry so whole frames fit in a short run
  localparam int SHFP = 2, SHS = 3, SHBP = 2, SHA = 8, SHT = 15;
  localparam int SVFP = 2, SVS = 2, SVBP = 3, SVA = 6, SVT = 13;

  localparam logic [25:0] RST_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic n_rst;
  logic enable;
  logic restart;
  int   errors = 0;
  int   checks = 0;

  // model state: enabled clocks since restart, plus pending pulse flags
  int t_b = 0, t_s = 0;
  bit le_b = 0, fs_b = 0, le_s = 0, fs_s = 0;

  always #5 clk = ~clk;

  video_timing_if if_b();
  video_timing_if if_s();
  assign if_b.enable  = enable;
  assign if_b.restart = restart;
  assign if_s.enable  = enable;
  assign if_s.restart = restart;

  video_timing_gen u_big (.clk(clk), .n_rst(n_rst), .vt(if_b));
  video_timing_gen #(
    .CLK_DIV(CD), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP), .H_ACTIVE(SHA),
    .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP), .V_ACTIVE(SVA), .SYNC_POL(1'b0)
  ) u_small (.clk(clk), .n_rst(n_rst), .vt(if_s));

  wire [25:0] obs_b = {if_b.pixelclk, if_b.colcount, if_b.rowcount, if_b.hsync,
                       if_b.vsync, if_b.de, if_b.line_end, if_b.frame_start};
  wire [25:0] obs_s = {if_s.pixelclk, if_s.colcount, if_s.rowcount, if_s.hsync,
                       if_s.vsync, if_s.de, if_s.line_end, if_s.frame_start};

  function automatic logic [25:0] expect_out(int t, bit le, bit fs, bit en, bit rs,
                                             int ht, int vt, int hfp, int hsw,
                                             int vfp, int vsw, int ha, int va);
    int p, col, row;
    bit pix, hs, vs, de;
    p   = t / CD;
    col = p % ht;
    row = (p / ht) % vt;
    pix = en && !rs && ((t % CD) == CD - 1);
    hs  = !((col >= hfp) && (col < hfp + hsw));
    vs  = !((row >= vfp) && (row < vfp + vsw));
    de  = (col >= ht - ha) && (row >= vt - va);
    return {pix, 10'(col), 10'(row), hs, vs, de, le && en, fs && en};
  endfunction

  function automatic logic [25:0] exp_b();
    return expect_out(t_b, le_b, fs_b, enable, restart, BHT, BVT, BHFP, BHS, BVFP, BVS, BHA, BVA);
  endfunction

  function automatic logic [25:0] exp_s();
    return expect_out(t_s, le_s, fs_s, enable, restart, SHT, SVT, SHFP, SHS, SVFP, SVS, SHA, SVA);
  endfunction

  task automatic advance_model(inout int t, inout bit le, inout bit fs, input int ht, input int vt);
    int p;
    if (!n_rst || restart) begin
      t = 0; le = 0; fs = 0;
    end else if (enable) begin
      if ((t % CD) == CD - 1) begin
        p  = t / CD + 1;
        le = (p % ht) == 0;
        fs = (p % (ht * vt)) == 0;
      end else begin
        le = 0; fs = 0;
      end
      t++;
    end else begin
      le = 0; fs = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    advance_model(t_b, le_b, fs_b, BHT, BVT);
    advance_model(t_s, le_s, fs_s, SHT, SVT);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; enable = 1'b1; restart = 1'b0;
    repeat (3) tick();
    #1;
    if (obs_b !== RST_VEC) begin errors++; $display("FAIL reset_big got=%h exp=%h", obs_b, RST_VEC); end
    checks++;
    if (obs_s !== RST_VEC) begin errors++; $display("FAIL reset_small got=%h exp=%h", obs_s, RST_VEC); end
    checks++;
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (if_b.pixelclk !== ((i % 4) == 3)) begin
        errors++; $display("FAIL first_pixelclk clk=%0d got=%b exp=%b", i + 1, if_b.pixelclk, (i % 4) == 3);
      end
      checks++;
      if (obs_s !== exp_s()) begin errors++; $display("FAIL reset_run_small t=%0d got=%h exp=%h", t_s, obs_s, exp_s()); end
      checks++;
      tick();
    end
  endtask

  task automatic test_line();
    int hs_low, first_col, last_col, le_cnt;
    hs_low = 0; first_col = -1; last_col = -1; le_cnt = 0;
    enable = 1'b1; restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 0; i <= 3200; i++) begin
      #1;
      if (obs_b !== exp_b()) begin errors++; $display("FAIL line_big t=%0d got=%h exp=%h", t_b, obs_b, exp_b()); end
      checks++;
      if (if_b.hsync === 1'b0) begin
        hs_low++;
        if (first_col < 0) first_col = int'(if_b.colcount);
        last_col = int'(if_b.colcount);
      end
      if (if_b.line_end === 1'b1) le_cnt++;
      tick();
    end
    #1;
    if (hs_low != 384 || first_col != 16 || last_col != 111) begin
      errors++; $display("FAIL hsync_window got=%0d clks cols %0d..%0d exp=384 clks cols 16..111", hs_low, first_col, last_col);
    end
    checks++;
    if (le_cnt != 1) begin errors++; $display("FAIL line_end_count got=%0d exp=1", le_cnt); end
    checks++;
    if (if_b.rowcount !== 10'd1) begin errors++; $display("FAIL row_after_line got=%0d exp=1", if_b.rowcount); end
    checks++;
  endtask

  task automatic test_frame();
    int pix_cnt, fs_cnt, fs_le, vs_min, vs_max, de_row, de_col;
    pix_cnt = 0; fs_cnt = 0; fs_le = 0; vs_min = 99; vs_max = -1; de_row = -1; de_col = -1;
    enable = 1'b1; restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 0; i <= 780; i++) begin
      #1;
      if (obs_s !== exp_s()) begin errors++; $display("FAIL frame_small t=%0d got=%h exp=%h", t_s, obs_s, exp_s()); end
      checks++;
      if (obs_b !== exp_b()) begin errors++; $display("FAIL frame_big t=%0d got=%h exp=%h", t_b, obs_b, exp_b()); end
      checks++;
      if (i < 780 && if_s.pixelclk === 1'b1) pix_cnt++;
      if (if_s.frame_start === 1'b1) begin
        fs_cnt++;
        if (if_s.line_end === 1'b1) fs_le++;
      end
      if (if_s.vsync === 1'b0) begin
        if (int'(if_s.rowcount) < vs_min) vs_min = int'(if_s.rowcount);
        if (int'(if_s.rowcount) > vs_max) vs_max = int'(if_s.rowcount);
      end
      if (if_s.de === 1'b1 && de_row < 0) begin
        de_row = int'(if_s.rowcount); de_col = int'(if_s.colcount);
      end
      tick();
    end
    if (pix_cnt != 195) begin errors++; $display("FAIL pixels_per_frame got=%0d exp=195", pix_cnt); end
    checks++;
    if (fs_cnt != 1 || fs_le != 1) begin errors++; $display("FAIL frame_start got=%0d with_le=%0d exp=1/1", fs_cnt, fs_le); end
    checks++;
    if (vs_min != 2 || vs_max != 3) begin errors++; $display("FAIL vsync_rows got=%0d..%0d exp=2..3", vs_min, vs_max); end
    checks++;
    if (de_row != 7 || de_col != 7) begin errors++; $display("FAIL first_de got=(%0d,%0d) exp=(7,7)", de_row, de_col); end
    checks++;
  endtask

  task automatic test_freeze();
    enable = 1'b1; restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (338) tick();   // small: row 5, col 9, div 2
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (if_s.colcount !== 10'd9 || if_s.rowcount !== 10'd5 || if_s.pixelclk !== 1'b0 || obs_s !== exp_s()) begin
        errors++; $display("FAIL freeze_small got=%h exp=%h col9 row5", obs_s, exp_s());
      end
      checks++;
      if (obs_b !== exp_b()) begin errors++; $display("FAIL freeze_big got=%h exp=%h", obs_b, exp_b()); end
      checks++;
      tick();
    end
    enable = 1'b1;
    #1;
    if (if_s.pixelclk !== 1'b0) begin errors++; $display("FAIL resume_clk1 got=%b exp=0", if_s.pixelclk); end
    checks++;
    tick(); #1;
    if (if_s.pixelclk !== 1'b1 || if_s.colcount !== 10'd9) begin
      errors++; $display("FAIL resume_clk2 got=pix%b col%0d exp=pix1 col9", if_s.pixelclk, if_s.colcount);
    end
    checks++;
    tick(); #1;
    if (if_s.colcount !== 10'd10) begin errors++; $display("FAIL resume_col got=%0d exp=10", if_s.colcount); end
    checks++;
  endtask

  task automatic test_restart();
    enable = 1'b1; restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (779) tick();   // small: row 12, col 14, div 3
    #1;
    if (if_s.pixelclk !== 1'b1) begin errors++; $display("FAIL pre_restart_pix got=%b exp=1", if_s.pixelclk); end
    checks++;
    restart = 1'b1;
    #1;
    if (if_s.pixelclk !== 1'b0) begin errors++; $display("FAIL restart_pix got=%b exp=0", if_s.pixelclk); end
    checks++;
    tick();
    restart = 1'b0;
    #1;
    if (obs_s !== RST_VEC) begin errors++; $display("FAIL restart_state got=%h exp=%h", obs_s, RST_VEC); end
    checks++;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (obs_s !== exp_s()) begin errors++; $display("FAIL after_restart t=%0d got=%h exp=%h", t_s, obs_s, exp_s()); end
      checks++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 249) == 0);
      #1;
      if (obs_s !== exp_s()) begin errors++; $display("FAIL random_small t=%0d got=%h exp=%h", t_s, obs_s, exp_s()); end
      checks++;
      if (obs_b !== exp_b()) begin errors++; $display("FAIL random_big t=%0d got=%h exp=%h", t_b, obs_b, exp_b()); end
      checks++;
      if (i == 1500) begin
        #1;
        n_rst = 1'b0;
        #1;
        if (obs_b !== RST_VEC || obs_s !== RST_VEC) begin
          errors++; $display("FAIL async_reset got=%h/%h exp=%h", obs_b, obs_s, RST_VEC);
        end
        checks++;
        tick();
        n_rst = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_freeze();
    test_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
